// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares the single main-memory port between three block requesters:
// icache reads (IC), dcache reads (DR) and dcache writebacks (DW).
// Only one transaction is in flight at a time. Winners are picked
// round-robin in IDLE, and a response watchdog bounds the wait for
// read data.
//
// Build option:
//   ARB_WRITE_PRIORITY_EN - when defined, a pending writeback always wins.
//                           IC and DR then alternate between themselves only.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   ic_req_*                  icache read request (valid/ready/addr)
//   ic_resp_*                 icache response pulse + block data
//   dc_rd_*                   dcache read request (valid/ready/addr)
//   dc_resp_*                 dcache response pulse + address + block data
//   dc_wr_*                   dcache writeback request (valid/ready/addr/data)
//   mem_rd_* / mem_wr_*       one-cycle request pulses to main memory
//   mem_resp_*                main-memory read response
//   busy_o                    a transaction is in progress
//   timeout_o                 one-cycle pulse when the watchdog gives up

module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int BLOCK_DW       = 256,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk_i,
    input  logic                rst_n_i,

    input  logic                ic_req_valid_i,
    output logic                ic_req_ready_o,
    input  logic [ADDR_W-1:0]   ic_req_addr_i,
    output logic                ic_resp_valid_o,
    output logic [BLOCK_DW-1:0] ic_resp_data_o,

    input  logic                dc_rd_valid_i,
    output logic                dc_rd_ready_o,
    input  logic [ADDR_W-1:0]   dc_rd_addr_i,
    output logic                dc_resp_valid_o,
    output logic [ADDR_W-1:0]   dc_resp_addr_o,
    output logic [BLOCK_DW-1:0] dc_resp_data_o,

    input  logic                dc_wr_valid_i,
    output logic                dc_wr_ready_o,
    input  logic [ADDR_W-1:0]   dc_wr_addr_i,
    input  logic [BLOCK_DW-1:0] dc_wr_data_i,

    output logic                mem_rd_valid_o,
    output logic [ADDR_W-1:0]   mem_rd_addr_o,
    output logic                mem_wr_valid_o,
    output logic [ADDR_W-1:0]   mem_wr_addr_o,
    output logic [BLOCK_DW-1:0] mem_wr_data_o,
    input  logic                mem_resp_valid_i,
    input  logic [BLOCK_DW-1:0] mem_resp_data_i,

    output logic                busy_o,
    output logic                timeout_o
);

    // Watchdog counter; a 1-bit stub keeps the width legal when disabled.
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Fire on the wait cycle whose increment makes the count reach
    // TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES wait cycles elapse.
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] IDX_IC = 2'd0;
    localparam logic [1:0] IDX_DR = 2'd1;
    localparam logic [1:0] IDX_DW = 2'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          last_q;
    logic [1:0]          gnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BLOCK_DW-1:0] wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                timeout_q;
    logic [BLOCK_DW-1:0] ic_data_q;
    logic [BLOCK_DW-1:0] dc_data_q;
    logic [ADDR_W-1:0]   dc_addr_q;

    logic [2:0]          vld;
    logic [1:0]          win_idx;
    logic                win_any;
    logic                arb_en;
    logic                accept;
    logic                resp_hit;
    logic                to_hit;

    assign vld = {dc_wr_valid_i, dc_rd_valid_i, ic_req_valid_i};

    // ------------------------------------------------------------------
    // Winner selection (combinational, used only in IDLE)
    // ------------------------------------------------------------------
`ifdef ARB_WRITE_PRIORITY_EN
    // Writebacks first; IC/DR alternate. last_q never holds DW here except
    // out of reset, where it is treated like DR so IC goes first.
    always_comb begin
        win_idx = IDX_IC;
        win_any = 1'b0;
        if (vld[IDX_DW]) begin
            win_idx = IDX_DW;
            win_any = 1'b1;
        end else if (last_q == IDX_IC) begin
            if (vld[IDX_DR]) begin
                win_idx = IDX_DR;
                win_any = 1'b1;
            end else if (vld[IDX_IC]) begin
                win_idx = IDX_IC;
                win_any = 1'b1;
            end
        end else begin
            if (vld[IDX_IC]) begin
                win_idx = IDX_IC;
                win_any = 1'b1;
            end else if (vld[IDX_DR]) begin
                win_idx = IDX_DR;
                win_any = 1'b1;
            end
        end
    end
`else
    logic [1:0] p0, p1, p2;

    // Priority order starts at (last+1) mod 3 and wraps.
    always_comb begin
        p0 = IDX_IC;
        p1 = IDX_DR;
        p2 = IDX_DW;
        case (last_q)
            IDX_IC: begin p0 = IDX_DR; p1 = IDX_DW; p2 = IDX_IC; end
            IDX_DR: begin p0 = IDX_DW; p1 = IDX_IC; p2 = IDX_DR; end
            default: begin p0 = IDX_IC; p1 = IDX_DR; p2 = IDX_DW; end
        endcase
    end

    always_comb begin
        win_idx = p0;
        win_any = 1'b1;
        if (vld[p0])      win_idx = p0;
        else if (vld[p1]) win_idx = p1;
        else if (vld[p2]) win_idx = p2;
        else              win_any = 1'b0;
    end
`endif

    // Gating with rst_n_i keeps ready low while reset is held, even though
    // the requesters may still be presenting valid.
    assign arb_en = (state_q == IDLE) && rst_n_i;
    assign accept = arb_en && win_any;

    assign ic_req_ready_o = accept && (win_idx == IDX_IC);
    assign dc_rd_ready_o  = accept && (win_idx == IDX_DR);
    assign dc_wr_ready_o  = accept && (win_idx == IDX_DW);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        resp_hit = 1'b0;
        to_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = (win_idx == IDX_DW) ? WR_REQ : RD_REQ;
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                // A response on the last allowed cycle still wins.
                if (mem_resp_valid_i) begin
                    resp_hit = 1'b1;
                    state_d  = RESP;
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    to_hit  = 1'b1;
                    state_d = RESP;
                end
            end
            WR_REQ:  state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            last_q    <= IDX_DW;
            gnt_q     <= IDX_IC;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            ic_data_q <= '0;
            dc_data_q <= '0;
            dc_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            timeout_q <= to_hit;

            if (accept) begin
                gnt_q <= win_idx;
`ifdef ARB_WRITE_PRIORITY_EN
                if (win_idx != IDX_DW)
                    last_q <= win_idx;
`else
                last_q <= win_idx;
`endif
                case (win_idx)
                    IDX_IC:  addr_q <= ic_req_addr_i;
                    IDX_DR:  addr_q <= dc_rd_addr_i;
                    default: begin
                        addr_q  <= dc_wr_addr_i;
                        wdata_q <= dc_wr_data_i;
                    end
                endcase
            end

            // Counter saturates instead of wrapping when the watchdog is off.
            if (state_q == RD_REQ)
                cnt_q <= '0;
            else if ((state_q == RD_WAIT) && !resp_hit && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;

            // Per-port data registers so each port's data holds until its
            // own next response, not the other port's.
            if (resp_hit || to_hit) begin
                if (gnt_q == IDX_IC) begin
                    ic_data_q <= resp_hit ? mem_resp_data_i : '0;
                end else begin
                    dc_data_q <= resp_hit ? mem_resp_data_i : '0;
                    dc_addr_q <= addr_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_rd_valid_o  = (state_q == RD_REQ);
    assign mem_rd_addr_o   = addr_q;
    assign mem_wr_valid_o  = (state_q == WR_REQ);
    assign mem_wr_addr_o   = addr_q;
    assign mem_wr_data_o   = wdata_q;

    assign ic_resp_valid_o = (state_q == RESP) && (gnt_q == IDX_IC);
    assign ic_resp_data_o  = ic_data_q;
    assign dc_resp_valid_o = (state_q == RESP) && (gnt_q == IDX_DR);
    assign dc_resp_addr_o  = dc_addr_q;
    assign dc_resp_data_o  = dc_data_q;

    assign busy_o          = (state_q != IDLE);
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. A transaction-level reference model
// predicts, per cycle, grants, memory pulses and response pulses from the
// accept cycle and the memory response schedule the bench itself creates.

module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int BW = 256;
    localparam int TO = 8;
    localparam int NS = 8192;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          ic_req_valid_i = 0, ic_req_ready_o, ic_resp_valid_o;
    logic [AW-1:0] ic_req_addr_i = '0;
    logic [BW-1:0] ic_resp_data_o;
    logic          dc_rd_valid_i = 0, dc_rd_ready_o, dc_resp_valid_o;
    logic [AW-1:0] dc_rd_addr_i = '0, dc_resp_addr_o;
    logic [BW-1:0] dc_resp_data_o;
    logic          dc_wr_valid_i = 0, dc_wr_ready_o;
    logic [AW-1:0] dc_wr_addr_i = '0;
    logic [BW-1:0] dc_wr_data_i = '0;
    logic          mem_rd_valid_o, mem_wr_valid_o;
    logic [AW-1:0] mem_rd_addr_o, mem_wr_addr_o;
    logic [BW-1:0] mem_wr_data_o;
    logic          mem_resp_valid_i = 0;
    logic [BW-1:0] mem_resp_data_i = '0;
    logic          busy_o, timeout_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(AW), .BLOCK_DW(BW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_req_addr_i(ic_req_addr_i), .ic_resp_valid_o(ic_resp_valid_o),
        .ic_resp_data_o(ic_resp_data_o),
        .dc_rd_valid_i(dc_rd_valid_i), .dc_rd_ready_o(dc_rd_ready_o),
        .dc_rd_addr_i(dc_rd_addr_i), .dc_resp_valid_o(dc_resp_valid_o),
        .dc_resp_addr_o(dc_resp_addr_o), .dc_resp_data_o(dc_resp_data_o),
        .dc_wr_valid_i(dc_wr_valid_i), .dc_wr_ready_o(dc_wr_ready_o),
        .dc_wr_addr_i(dc_wr_addr_i), .dc_wr_data_i(dc_wr_data_i),
        .mem_rd_valid_o(mem_rd_valid_o), .mem_rd_addr_o(mem_rd_addr_o),
        .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requesters (index 0=IC, 1=DR, 2=DW), memory response schedule.
    bit            rq_v[3];
    logic [AW-1:0] rq_a[3];
    logic [BW-1:0] rq_d;
    bit            sv[NS];
    logic [BW-1:0] sd[NS];
    int            c = 0;
    int            mode = 0;       // 0 directed only, 1 all valid, 2 random
    int            force_lat = 0;
    logic [BW-1:0] force_dat = '0;
    int            glog[$];

    // Reference model: current transaction as (accept cycle, kind, outcome).
    bit            act, rd, res, tmo;
    int            t, rc, gi;
    int            last = 2;
    logic [AW-1:0] ca;
    logic [BW-1:0] cd, rdat, ic_hold, dc_hold;
    logic [AW-1:0] dca_hold;

    function automatic logic [BW-1:0] rnd256();
        logic [BW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pick();
`ifdef ARB_WRITE_PRIORITY_EN
        int base;
        if (rq_v[2]) return 2;
        base = (last == 2) ? 1 : last;
        for (int k = 1; k <= 2; k++) if (rq_v[(base + k) % 2]) return (base + k) % 2;
`else
        for (int k = 1; k <= 3; k++) if (rq_v[(last + k) % 3]) return (last + k) % 3;
`endif
        return -1;
    endfunction

    task automatic mreset();
        act = 0; res = 0; tmo = 0; last = 2;
        ic_hold = '0; dc_hold = '0; dca_hold = '0;
    endtask

    task automatic req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] d);
        rq_v[i] = 1; rq_a[i] = a;
        if (i == 2) rq_d = d;
    endtask

    task automatic gen();
        for (int i = 0; i < 3; i++) begin
            if (!rq_v[i] && (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)))
                req(i, $urandom & 32'hffff_ffe0, rnd256());
        end
        if (mode == 2 && $urandom_range(0, 29) == 0 && c + 2 < NS) begin
            sv[c+2] = 1; sd[c+2] = rnd256();
        end
    endtask

    task automatic drive();
        ic_req_valid_i = rq_v[0]; ic_req_addr_i = rq_a[0];
        dc_rd_valid_i  = rq_v[1]; dc_rd_addr_i  = rq_a[1];
        dc_wr_valid_i  = rq_v[2]; dc_wr_addr_i  = rq_a[2]; dc_wr_data_i = rq_d;
        mem_resp_valid_i = sv[c];
        mem_resp_data_i  = sd[c];
    endtask

    task automatic model();
        bit idle, rdp, wrp, rp;
        int w, lat, r;
        idle = !act;
        // Resolve an outstanding read from the schedule of the previous cycle.
        if (act && rd && !res && c - 1 >= t + 2 && c - 1 <= t + 1 + TO) begin
            if (sv[c-1]) begin
                res = 1; rc = c; rdat = sd[c-1]; tmo = 0;
            end else if (c - 1 == t + 1 + TO) begin
                res = 1; rc = c; rdat = '0; tmo = 1;
            end
        end
        w = idle ? pick() : -1;
        chk("ic_ready", ic_req_ready_o, w == 0);
        chk("dr_ready", dc_rd_ready_o, w == 1);
        chk("dw_ready", dc_wr_ready_o, w == 2);
        chk("busy", busy_o, act);
        rdp = act && rd && (c == t + 1);
        wrp = act && !rd && (c == t + 1);
        chk("mem_rd_valid", mem_rd_valid_o, rdp);
        if (rdp) chk("mem_rd_addr", mem_rd_addr_o, ca);
        chk("mem_wr_valid", mem_wr_valid_o, wrp);
        if (wrp) begin
            chk("mem_wr_addr", mem_wr_addr_o, ca);
            chk("mem_wr_data", mem_wr_data_o, cd);
        end
        rp = act && rd && res && (c == rc);
        if (rp) begin
            if (gi == 0) ic_hold = rdat;
            else begin dc_hold = rdat; dca_hold = ca; end
        end
        chk("ic_resp_valid", ic_resp_valid_o, rp && gi == 0);
        chk("dc_resp_valid", dc_resp_valid_o, rp && gi == 1);
        chk("timeout", timeout_o, rp && tmo);
        chk("ic_resp_data", ic_resp_data_o, ic_hold);
        chk("dc_resp_data", dc_resp_data_o, dc_hold);
        chk("dc_resp_addr", dc_resp_addr_o, dca_hold);
        if (wrp || rp) act = 0;
        if (w >= 0) begin
            act = 1; t = c; gi = w; rd = (w != 2); res = 0; tmo = 0;
            ca = rq_a[w]; cd = rq_d; rq_v[w] = 0;
            glog.push_back(w);
`ifdef ARB_WRITE_PRIORITY_EN
            if (w != 2) last = w;
`else
            last = w;
`endif
            if (rd) begin
                lat = (force_lat != 0) ? force_lat : $urandom_range(1, 12);
                r = c + 1 + lat;
                if (r < NS) begin
                    sv[r] = 1;
                    sd[r] = (force_lat != 0) ? force_dat : rnd256();
                end
            end
        end
    endtask

    task automatic check_zero();
        chk("rst_ic_ready", ic_req_ready_o, 0);
        chk("rst_dr_ready", dc_rd_ready_o, 0);
        chk("rst_dw_ready", dc_wr_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_rd", {mem_rd_valid_o, mem_rd_addr_o}, 0);
        chk("rst_mem_wr", {mem_wr_valid_o, mem_wr_addr_o}, 0);
        chk("rst_mem_wdata", mem_wr_data_o, 0);
        chk("rst_resp_valid", {ic_resp_valid_o, dc_resp_valid_o, timeout_o}, 0);
        chk("rst_ic_data", ic_resp_data_o, 0);
        chk("rst_dc_data", dc_resp_data_o, 0);
        chk("rst_dc_addr", dc_resp_addr_o, 0);
    endtask

    task automatic step();
        @(posedge clk_i); #1; c++;
        gen(); drive();
        @(negedge clk_i); model();
    endtask

    task automatic rst_cycle(input bit assert_now);
        @(posedge clk_i); #1; c++;
        if (assert_now) begin
            rst_n_i = 0;
            mreset();
        end
        drive();
        #1 check_zero();
        @(negedge clk_i); check_zero();
    endtask

    task automatic rel();
        @(posedge clk_i); #1; c++;
        rst_n_i = 1;
        gen(); drive();
        @(negedge clk_i); model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        mreset();
        // Reset state.
        repeat (3) rst_cycle(0);
        rel();

        // IC read, memory answers 3 cycles after the read pulse with A5 data.
        force_lat = 3;
        force_dat = {32{8'hA5}};
        req(0, 32'h0000_1000, '0);
        repeat (10) step();
        chk("ic_a5_data", ic_resp_data_o, {32{8'hA5}});
        force_lat = 0;

        // DW and DR to the same address together with last=IC.
        glog.delete();
        req(1, 32'h0000_4000, '0);
        req(2, 32'h0000_4000, rnd256());
        repeat (30) step();
`ifdef ARB_WRITE_PRIORITY_EN
        chk("order_first", glog.size() > 0 ? glog[0] : -1, 2);
        chk("order_second", glog.size() > 1 ? glog[1] : -1, 1);
`else
        chk("order_first", glog.size() > 0 ? glog[0] : -1, 1);
        chk("order_second", glog.size() > 1 ? glog[1] : -1, 2);
`endif

        // Writeback with a recognisable pattern.
        req(2, 32'h0000_2000, {16'hDEAD, {28{8'h00}}, 16'hBEEF});
        repeat (5) step();

        // All three valid continuously from reset.
        rst_cycle(1);
        rst_cycle(0);
        mode = 1;
        glog.delete();
        rel();
        repeat (80) step();
        chk("rr_grant_count", glog.size() >= 6, 1);
        for (int i = 0; i < 6 && i < glog.size(); i++) begin
`ifdef ARB_WRITE_PRIORITY_EN
            chk("rr_order", glog[i], 2);
`else
            chk("rr_order", glog[i], i % 3);
`endif
        end

        // Random traffic.
        mode = 2;
        repeat (1500) step();

        // Reset in the middle of a read wait; response arrives after release.
        n = 0;
        while (!(act && rd && !res && c >= t + 1 && c < t + 1 + TO && !sv[c]) && n < 300) begin
            step(); n++;
        end
        chk("rdwait_found", n < 300, 1);
        rst_cycle(1);
        rst_cycle(0);
        rst_cycle(0);
        if (c + 2 < NS) begin sv[c+2] = 1; sd[c+2] = rnd256(); end
        rq_v[0] = 1; rq_a[0] = 32'h0000_5000;
        rel();
        chk("ic_fresh_grant", glog.size() > 0 ? glog[glog.size()-1] : -1, 0);
        repeat (300) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
